// File: rtl/object_fetch.sv
// -----------------------------------------------------------------------------
// object_fetch
//   Holds a table of NUM_OBJ sprite descriptors {h, w, base}. On each request it
//   looks up one descriptor and streams the sprite's ROM addresses in raster
//   order. Each beat carries its pixel coordinate.
//
//   Ports
//     clk, rst           clock (rising edge), synchronous active-high reset
//     cfg_we, cfg_*      descriptor write port (ids >= NUM_OBJ are dropped)
//     req_*              fetch request handshake (req_ready only while idle)
//     pix_*              pixel address stream (valid/ready, pix_last on final beat)
//     done, err          one-cycle completion pulse; err qualifies a rejected
//                        request (bad id or empty sprite)
//
//   Build option
//     OBJECT_FETCH_MIRROR_EN  when defined, req_flip=1 mirrors each row
//                             horizontally (addresses walk right-to-left).
// -----------------------------------------------------------------------------
module object_fetch #(
    parameter int NUM_OBJ = 36,
    parameter int ID_W    = 6,
    parameter int DIM_W   = 11,
    parameter int ADDR_W  = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ID_W-1:0]   cfg_id,
    input  logic [DIM_W-1:0]  cfg_h,
    input  logic [DIM_W-1:0]  cfg_w,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ID_W-1:0]   req_id,
    input  logic              req_flip,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [DIM_W-1:0]  pix_x,
    output logic [DIM_W-1:0]  pix_y,
    output logic              pix_last,
    output logic              done,
    output logic              err
);

    // One extra bit so NUM_OBJ == 2**ID_W still compares correctly.
    localparam logic [ID_W:0] NUM_OBJ_C = (ID_W+1)'(NUM_OBJ);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_STREAM} state_t;

    // ---------------- descriptor table ----------------
    logic [DIM_W-1:0]  h_mem    [NUM_OBJ];
    logic [DIM_W-1:0]  w_mem    [NUM_OBJ];
    logic [ADDR_W-1:0] base_mem [NUM_OBJ];

    logic cfg_ok;
    assign cfg_ok = ({1'b0, cfg_id} < NUM_OBJ_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                h_mem[i]    <= '0;
                w_mem[i]    <= '0;
                base_mem[i] <= '0;
            end
        end else if (cfg_we && cfg_ok) begin
            h_mem[cfg_id]    <= cfg_h;
            w_mem[cfg_id]    <= cfg_w;
            base_mem[cfg_id] <= cfg_addr;
        end
    end

    // ---------------- fetch state ----------------
    state_t            state_q;
    logic [ID_W-1:0]   id_q;
    logic [DIM_W-1:0]  h_q, w_q, x_q, y_q;
    logic [ADDR_W-1:0] row_q;     // base + y*w, kept incrementally
    logic [ADDR_W-1:0] addr_q;
    logic              ready_q, valid_q, last_q, done_q, err_q;

    // Lookup reads the table's registered contents, so a same-cycle cfg write
    // to this id is not seen; out-of-range ids read as an empty sprite.
    logic              id_ok;
    logic [DIM_W-1:0]  lk_h, lk_w;
    logic [ADDR_W-1:0] lk_base;
    assign id_ok   = ({1'b0, id_q} < NUM_OBJ_C);
    assign lk_h    = id_ok ? h_mem[id_q]    : '0;
    assign lk_w    = id_ok ? w_mem[id_q]    : '0;
    assign lk_base = id_ok ? base_mem[id_q] : '0;

    logic [ADDR_W-1:0] w_ext, first_addr, next_row_addr, step_addr;
    assign w_ext = ADDR_W'(w_q);

`ifdef OBJECT_FETCH_MIRROR_EN
    logic flip_q;
    always_ff @(posedge clk) begin
        if (rst)
            flip_q <= 1'b0;
        else if (state_q == S_IDLE && req_valid)
            flip_q <= req_flip;
    end
    // Mirrored rows start at the right edge and walk down by one.
    assign first_addr    = flip_q ? lk_base + ADDR_W'(lk_w) - 1'b1 : lk_base;
    assign next_row_addr = flip_q ? row_q + w_ext + w_ext - 1'b1 : row_q + w_ext;
    assign step_addr     = flip_q ? addr_q - 1'b1 : addr_q + 1'b1;
`else
    logic unused_flip;
    assign unused_flip   = req_flip;
    assign first_addr    = lk_base;
    assign next_row_addr = row_q + w_ext;
    assign step_addr     = addr_q + 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            h_q     <= '0;
            w_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        id_q    <= req_id;
                        ready_q <= 1'b0;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (!id_ok || lk_h == '0 || lk_w == '0) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        h_q     <= lk_h;
                        w_q     <= lk_w;
                        x_q     <= '0;
                        y_q     <= '0;
                        row_q   <= lk_base;
                        addr_q  <= first_addr;
                        last_q  <= (lk_h == DIM_W'(1)) && (lk_w == DIM_W'(1));
                        valid_q <= 1'b1;
                        state_q <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (pix_ready) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else if (x_q == w_q - 1'b1) begin
                            // End of row: jump to start of the next row.
                            x_q    <= '0;
                            y_q    <= y_q + 1'b1;
                            row_q  <= row_q + w_ext;
                            addr_q <= next_row_addr;
                            last_q <= (w_q == DIM_W'(1)) && (y_q + 1'b1 == h_q - 1'b1);
                        end else begin
                            x_q    <= x_q + 1'b1;
                            addr_q <= step_addr;
                            last_q <= (x_q + 1'b1 == w_q - 1'b1) && (y_q == h_q - 1'b1);
                        end
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign pix_valid = valid_q;
    assign pix_addr  = addr_q;
    assign pix_x     = x_q;
    assign pix_y     = y_q;
    assign pix_last  = last_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_object_fetch.sv
// Bench for object_fetch: directed steps in one initial block, expected beats
// queued per fetch and popped by a negedge monitor as the DUT emits them.
module tb_object_fetch;
    localparam int ADDR_W = 19;
`ifdef OBJECT_FETCH_MIRROR_EN
    localparam bit MIRROR = 1'b1;
`else
    localparam bit MIRROR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, cfg_we, req_valid, req_ready, req_flip;
    logic [5:0]  cfg_id, req_id;
    logic [10:0] cfg_h, cfg_w, pix_x, pix_y;
    logic [18:0] cfg_addr, pix_addr;
    logic        pix_valid, pix_ready, pix_last, done, err;

    always #5 clk = ~clk;

    object_fetch dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_h(cfg_h),
        .cfg_w(cfg_w), .cfg_addr(cfg_addr), .req_valid(req_valid),
        .req_ready(req_ready), .req_id(req_id), .req_flip(req_flip),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_addr(pix_addr),
        .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last), .done(done), .err(err)
    );

    typedef struct {
        int addr;
        int x;
        int y;
        bit last;
    } beat_t;

    beat_t q[$];
    beat_t mon_e;
    int    checks   = 0;
    int    failures = 0;
    int    beats    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference raster walk, using a multiply per beat.
    task automatic push_exp(input int h, input int w, input int base, input bit flip);
        beat_t e;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                e.addr = (base + y * w + ((flip && MIRROR) ? (w - 1 - x) : x)) % (1 << ADDR_W);
                e.x    = x;
                e.y    = y;
                e.last = (x == w - 1) && (y == h - 1);
                q.push_back(e);
            end
    endtask

    // Every valid beat must match the queue head; stalled beats must too.
    always @(negedge clk) begin
        if (pix_valid && !rst) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
                mon_e = q[0];
                chk(pix_ready ? "addr" : "stall_addr", 32'(pix_addr), mon_e.addr);
                chk(pix_ready ? "x" : "stall_x", 32'(pix_x), mon_e.x);
                chk(pix_ready ? "y" : "stall_y", 32'(pix_y), mon_e.y);
                chk(pix_ready ? "last" : "stall_last", 32'(pix_last), 32'(mon_e.last));
                if (pix_ready) begin
                    void'(q.pop_front());
                    beats++;
                end
            end
        end
    end

    task automatic cfg(input int id, input int h, input int w, input int base);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_id = 6'(id); cfg_h = 11'(h); cfg_w = 11'(w); cfg_addr = 19'(base);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // One request; optional stall on a beat index, mid-stream rewrite of id 3,
    // or a reset while a given beat index is presented (-1 disables each).
    task automatic fetch(input int id, input bit flip, input bit exp_err,
                         input int stall_beat, input int cfg_beat, input int rst_beat);
        bit fin = 0, aborted = 0, cfg_done = 0;
        int stalls = 0;
        beats = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_id = 6'(id); req_flip = flip;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("lookup_no_valid", 32'(pix_valid), 32'd0);
        chk("lookup_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("first_valid", 32'(pix_valid), 32'(!exp_err));
        chk("lat_done", 32'(done), 32'(exp_err));
        chk("lat_err", 32'(err), 32'(exp_err));
        if (exp_err) begin
            fin = 1;
        end else begin
            for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
                @(posedge clk); #1;
                cfg_we = 1'b0;
                if (beats == cfg_beat && !cfg_done) begin
                    cfg_we = 1'b1; cfg_id = 6'd3; cfg_h = 11'd1; cfg_w = 11'd1; cfg_addr = '0;
                    cfg_done = 1;
                end
                if (beats == rst_beat) rst = 1'b1;
                if (beats == stall_beat && stalls < 4) begin
                    pix_ready = 1'b0;
                    stalls++;
                end else begin
                    pix_ready = 1'b1;
                end
                @(negedge clk);
                if (rst) begin
                    fin = 1; aborted = 1;
                end else if (done) begin
                    fin = 1;
                end
            end
            cfg_we = 1'b0;
        end
        chk("fetch_finished", 32'(fin), 32'd1);
        if (aborted) begin
            @(posedge clk); #1;
            rst = 1'b0;
            q.delete();
            @(negedge clk);
            chk("rst_valid", 32'(pix_valid), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_ready", 32'(req_ready), 32'd1);
            chk("rst_addr", 32'(pix_addr), 32'd0);
        end else begin
            if (!exp_err) begin
                chk("done_err", 32'(err), 32'd0);
                chk("done_ready", 32'(req_ready), 32'd1);
                chk("done_valid", 32'(pix_valid), 32'd0);
                chk("beats_left", 32'(q.size()), 32'd0);
            end
            @(negedge clk);
            chk("done_pulse", 32'(done), 32'd0);
            chk("err_pulse", 32'(err), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_id = '0; cfg_h = '0; cfg_w = '0; cfg_addr = '0;
        req_valid = 1'b0; req_id = '0; req_flip = 1'b0; pix_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_valid", 32'(pix_valid), 32'd0);
        chk("reset_addr", 32'(pix_addr), 32'd0);
        chk("reset_last", 32'(pix_last), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);

        cfg(3, 2, 3, 100);
        cfg(5, 4, 0, 7);          // w = 0
        cfg(6, 0, 2, 9);          // h = 0
        cfg(35, 3, 2, 524285);    // last legal id, address wraps
        cfg(36, 1, 1, 1);         // out of range, dropped

        push_exp(2, 3, 100, 0); fetch(3, 0, 0, -1, -1, -1);   // basic stream
        push_exp(2, 3, 100, 0); fetch(3, 0, 0, 1, -1, -1);    // stall on beat 2
        push_exp(2, 3, 100, 1); fetch(3, 1, 0, -1, -1, -1);   // flip request
        push_exp(3, 2, 524285, 0); fetch(35, 0, 0, -1, -1, -1);

        fetch(40, 0, 1, -1, -1, -1);
        fetch(36, 0, 1, -1, -1, -1);
        fetch(5, 0, 1, -1, -1, -1);
        fetch(6, 0, 1, -1, -1, -1);

        push_exp(2, 3, 100, 0); fetch(3, 0, 0, -1, 2, -1);    // rewrite id 3 mid-stream
        push_exp(1, 1, 0, 0);   fetch(3, 0, 0, -1, -1, -1);

        cfg(3, 2, 3, 100);
        push_exp(2, 3, 100, 0); fetch(3, 0, 0, -1, -1, 2);    // reset on beat 3
        fetch(3, 0, 1, -1, -1, -1);
        fetch(35, 0, 1, -1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
